// File: rtl/dmac_channel_arbiter_if.sv
// rtl/dmac_channel_arbiter_if.sv - request/bus/engine/interrupt signal bundle for the DMA channel arbiter
//
// Purpose: groups every non-clock, non-reset signal of dmac_channel_arbiter.
//   slave  modport : arbiter view (peripheral/config/grant/done in, bus/engine/irq out)
//   master modport : surrounding system view (drives requests, config, grant, done)
// Signals:
//   DmacReq[NUM_CH]   peripheral level requests
//   ChEnable[NUM_CH]  channel enabled by config registers
//   Bus_Grant         AHB arbiter grant
//   ChDone            transfer-engine completion pulse
//   IntMask[NUM_CH]   per-channel interrupt enable
//   IntClear[NUM_CH]  write-1-to-clear strobe for IntStatus
//   Bus_Req           AHB bus request
//   ChSel[CH_W]       channel being served
//   ChStart           one-cycle start pulse to the transfer engine
//   ChHold            pause to the transfer engine while grant is lost
//   Busy              arbiter not idle
//   ReqAck[NUM_CH]    one-hot acknowledge to the served peripheral
//   IntStatus[NUM_CH] sticky completion flags
//   Interrupt         masked OR of IntStatus
interface dmac_channel_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] DmacReq;
    logic [NUM_CH-1:0] ChEnable;
    logic              Bus_Grant;
    logic              ChDone;
    logic [NUM_CH-1:0] IntMask;
    logic [NUM_CH-1:0] IntClear;
    logic              Bus_Req;
    logic [CH_W-1:0]   ChSel;
    logic              ChStart;
    logic              ChHold;
    logic              Busy;
    logic [NUM_CH-1:0] ReqAck;
    logic [NUM_CH-1:0] IntStatus;
    logic              Interrupt;

    modport slave (
        input  DmacReq, ChEnable, Bus_Grant, ChDone, IntMask, IntClear,
        output Bus_Req, ChSel, ChStart, ChHold, Busy, ReqAck, IntStatus, Interrupt
    );

    modport master (
        output DmacReq, ChEnable, Bus_Grant, ChDone, IntMask, IntClear,
        input  Bus_Req, ChSel, ChStart, ChHold, Busy, ReqAck, IntStatus, Interrupt
    );
endinterface

// File: rtl/dmac_channel_arbiter.sv
// rtl/dmac_channel_arbiter.sv - N-channel DMA request arbiter and AHB bus-handshake sequencer
//
// Purpose: picks one enabled, requesting channel (round-robin or fixed priority),
//   requests the AHB bus, starts the transfer engine, waits for completion,
//   acknowledges the peripheral and flags a per-channel completion interrupt.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - dmac_channel_arbiter_if.slave (requests, enables, grant, done,
//          interrupt mask/clear in; bus request, channel select, start/hold,
//          busy, ack, interrupt status/line out)
module dmac_channel_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int PRIO_MODE = 0,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    dmac_channel_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_START  = 3'd2,
        S_ACTIVE = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam logic [CH_W-1:0]   PTR_RST  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]     NUM_CH_W = (CH_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   chsel_q, chsel_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] int_status_q, int_status_d;

    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   win_idx;
    logic [CH_W:0]     cand;
    logic [NUM_CH-1:0] ack_vec;

    assign eligible = bus.DmacReq & bus.ChEnable;

    // Winner selection. Both loops scan in reverse so the last hit, i.e. the
    // lowest index (fixed) or the nearest channel after the pointer (round-robin),
    // is the one that sticks.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    win_idx = CH_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = {1'b0, ptr_q} + (CH_W + 1)'(k);
                if (cand >= NUM_CH_W) begin
                    cand = cand - NUM_CH_W;
                end
                if (eligible[cand[CH_W-1:0]]) begin
                    win_idx = cand[CH_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            chsel_q      <= '0;
            ptr_q        <= PTR_RST;
            int_status_q <= '0;
        end else begin
            state_q      <= state_d;
            chsel_q      <= chsel_d;
            ptr_q        <= ptr_d;
            int_status_q <= int_status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chsel_d = chsel_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_REQ;
                    chsel_d = win_idx;
                end
            end
            S_REQ: begin
                // A grant arriving in the same cycle the request drops still
                // commits the transfer; withdrawal only aborts before the grant.
                if (bus.Bus_Grant) begin
                    state_d = S_START;
                end else if (!eligible[chsel_q]) begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (bus.ChDone) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                ptr_d   = chsel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack_vec = (state_q == S_ACK) ? (ONE_HOT0 << chsel_q) : '0;

    // Setting in ACK is OR-ed after the clear so a same-cycle clear loses.
    assign int_status_d = (int_status_q & ~bus.IntClear) | ack_vec;

    assign bus.Bus_Req   = (state_q == S_REQ) || (state_q == S_START) || (state_q == S_ACTIVE);
    assign bus.ChSel     = chsel_q;
    assign bus.ChStart   = (state_q == S_START);
    assign bus.ChHold    = (state_q == S_ACTIVE) && !bus.Bus_Grant;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.ReqAck    = ack_vec;
    assign bus.IntStatus = int_status_q;
    assign bus.Interrupt = |(int_status_q & bus.IntMask);

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// tb/tb_dmac_channel_arbiter.sv - self-checking bench for dmac_channel_arbiter
module tb_dmac_channel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_dly = 10;
    int rr_eng = 0;
    int fp_eng = 0;
    int exp_q[$];

    dmac_channel_arbiter_if #(.NUM_CH(4)) rr_if ();
    dmac_channel_arbiter_if #(.NUM_CH(4)) fp_if ();

    dmac_channel_arbiter #(.NUM_CH(4), .PRIO_MODE(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (rr_if.slave)
    );

    dmac_channel_arbiter #(.NUM_CH(4), .PRIO_MODE(1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (fp_if.slave)
    );

    // Transfer-engine models: pulse ChDone done_dly cycles after ChStart.
    always @(negedge clk) begin
        rr_if.ChDone = 1'b0;
        if (!rst) begin
            rr_eng = 0;
        end else begin
            if (rr_eng > 0) begin
                rr_eng--;
                if (rr_eng == 0) rr_if.ChDone = 1'b1;
            end
            if (rr_if.ChStart) rr_eng = done_dly;
        end
    end

    always @(negedge clk) begin
        fp_if.ChDone = 1'b0;
        if (!rst) begin
            fp_eng = 0;
        end else begin
            if (fp_eng > 0) begin
                fp_eng--;
                if (fp_eng == 0) fp_if.ChDone = 1'b1;
            end
            if (fp_if.ChStart) fp_eng = done_dly;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_rr_ack(input int budget, output logic [3:0] ack, output int cyc);
        ack = '0;
        cyc = 0;
        while (ack == 4'b0000 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            ack = rr_if.ReqAck;
        end
    endtask

    task automatic wait_rr_start(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rr_if.ChStart && cyc < budget);
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rr_if.DmacReq = 4'b0010; rr_if.ChEnable = 4'b0010; rr_if.Bus_Grant = 1'b1;
        rr_if.IntMask = 4'b0010; rr_if.IntClear = 4'b0000;
        fp_if.DmacReq = 4'b0000; fp_if.ChEnable = 4'b0000; fp_if.Bus_Grant = 1'b0;
        fp_if.IntMask = 4'b0000; fp_if.IntClear = 4'b0000;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            obs = {rr_if.Bus_Req, rr_if.ChStart, rr_if.ChHold, rr_if.Busy, rr_if.Interrupt,
                   rr_if.ChSel, rr_if.ReqAck, rr_if.IntStatus[2:0]};
            checks++;
            if (obs !== 14'd0 || rr_if.IntStatus[3] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %b required all zero", c, obs);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_single_channel();
        int n;
        int m;
        logic [3:0] ack;
        int e;
        done_dly = 10;
        exp_q.push_back(1);
        @(negedge clk);
        checks++;
        if (rr_if.ChSel !== 2'd1 || rr_if.Bus_Req !== 1'b1 || rr_if.ChStart !== 1'b0) begin
            errors++;
            $display("FAIL single_req_state chsel %0d bus_req %b start %b required 1 1 0",
                     rr_if.ChSel, rr_if.Bus_Req, rr_if.ChStart);
        end
        n = 1;
        while (!rr_if.ChStart && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL single_start_latency got %0d required 2", n);
        end
        wait_rr_ack(60, ack, m);
        e = exp_q.pop_front();
        checks++;
        if (ack !== (4'b0001 << e) || m !== 11) begin
            errors++;
            $display("FAIL single_ack got %b after %0d cycles required %b after 11", ack, m, 4'b0001 << e);
        end
        checks++;
        if (rr_if.Bus_Req !== 1'b0) begin
            errors++;
            $display("FAIL single_busreq_in_ack got %b required 0", rr_if.Bus_Req);
        end
        rr_if.DmacReq = 4'b0000;
        @(negedge clk);
        checks++;
        if (rr_if.IntStatus !== 4'b0010 || rr_if.Interrupt !== 1'b1 || rr_if.Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_irq status %b irq %b busy %b required 0010 1 0",
                     rr_if.IntStatus, rr_if.Interrupt, rr_if.Busy);
        end
        rr_if.IntClear = 4'b0010;
        @(negedge clk);
        rr_if.IntClear = 4'b0000;
        checks++;
        if (rr_if.IntStatus !== 4'b0000 || rr_if.Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL single_clear status %b irq %b required 0000 0", rr_if.IntStatus, rr_if.Interrupt);
        end
    endtask

    task automatic test_round_robin();
        int tmr[4];
        int acks;
        int cyc;
        int e;
        logic [3:0] ack;
        do_reset();
        done_dly = 3;
        for (int i = 0; i < 4; i++) tmr[i] = 0;
        rr_if.ChEnable = 4'b1111; rr_if.DmacReq = 4'b1111; rr_if.Bus_Grant = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        acks = 0;
        cyc = 0;
        while (acks < 5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) rr_if.DmacReq[i] = 1'b1;
                end
            end
            ack = rr_if.ReqAck;
            if (ack != 4'b0000) begin
                e = exp_q.pop_front();
                checks++;
                if (ack !== (4'b0001 << e) || rr_if.ChSel !== 2'(e)) begin
                    errors++;
                    $display("FAIL rr_order ack %0d got %b chsel %0d required %b", acks, ack, rr_if.ChSel, 4'b0001 << e);
                end
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) begin
                        rr_if.DmacReq[i] = 1'b0;
                        tmr[i] = 3;
                    end
                end
                acks++;
            end
        end
        rr_if.DmacReq = 4'b0000;
        checks++;
        if (acks !== 5) begin
            errors++;
            $display("FAIL rr_timeout got %0d acks required 5", acks);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rr_if.IntClear = 4'b1111;
        @(negedge clk);
        rr_if.IntClear = 4'b0000;
    endtask

    task automatic test_fixed_priority();
        int acks;
        int cyc;
        int e;
        logic [3:0] ack;
        done_dly = 3;
        fp_if.ChEnable = 4'b1111; fp_if.DmacReq = 4'b1111; fp_if.Bus_Grant = 1'b1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        acks = 0;
        cyc = 0;
        while (acks < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ack = fp_if.ReqAck;
            if (ack != 4'b0000) begin
                e = exp_q.pop_front();
                checks++;
                if (ack !== (4'b0001 << e)) begin
                    errors++;
                    $display("FAIL fp_order ack %0d got %b required %b", acks, ack, 4'b0001 << e);
                end
                acks++;
            end
        end
        fp_if.DmacReq = 4'b0000;
        checks++;
        if (acks !== 3) begin
            errors++;
            $display("FAIL fp_timeout got %0d acks required 3", acks);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_grant_delay();
        int breq_low;
        int early_start;
        int hold_cnt;
        int not_active;
        int m;
        int e;
        logic [3:0] ack;
        done_dly = 12;
        rr_if.ChEnable = 4'b0100; rr_if.Bus_Grant = 1'b0; rr_if.DmacReq = 4'b0100;
        exp_q.push_back(2);
        breq_low = 0; early_start = 0; hold_cnt = 0; not_active = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!rr_if.Bus_Req) breq_low++;
            if (rr_if.ChStart) early_start++;
        end
        rr_if.Bus_Grant = 1'b1;
        @(negedge clk);
        checks++;
        if (rr_if.ChStart !== 1'b1 || early_start !== 0) begin
            errors++;
            $display("FAIL grant_start start %b early %0d required 1 0", rr_if.ChStart, early_start);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rr_if.Bus_Grant = (k <= 3) ? 1'b0 : 1'b1;
            #1;
            if (rr_if.ChHold) hold_cnt++;
            if (!rr_if.Bus_Req) breq_low++;
            if (!rr_if.Busy || rr_if.ChStart || rr_if.ReqAck != 4'b0000) not_active++;
        end
        checks++;
        if (hold_cnt !== 3) begin
            errors++;
            $display("FAIL grant_hold_cycles got %0d required 3", hold_cnt);
        end
        checks++;
        if (breq_low !== 0 || not_active !== 0) begin
            errors++;
            $display("FAIL grant_busreq low %0d left_active %0d required 0 0", breq_low, not_active);
        end
        wait_rr_ack(40, ack, m);
        e = exp_q.pop_front();
        rr_if.DmacReq = 4'b0000;
        checks++;
        if (ack !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL grant_ack got %b required %b", ack, 4'b0001 << e);
        end
        @(negedge clk);
        rr_if.IntClear = 4'b1111;
        @(negedge clk);
        rr_if.IntClear = 4'b0000;
    endtask

    task automatic test_withdraw_disabled();
        int starts;
        int acks;
        int busy;
        int m;
        int e;
        logic [3:0] ack;
        rr_if.ChEnable = 4'b0111; rr_if.Bus_Grant = 1'b0; rr_if.DmacReq = 4'b0100;
        @(negedge clk);
        checks++;
        if (rr_if.Busy !== 1'b1 || rr_if.Bus_Req !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_in_req busy %b bus_req %b required 1 1", rr_if.Busy, rr_if.Bus_Req);
        end
        rr_if.DmacReq = 4'b0000;
        @(negedge clk);
        checks++;
        if (rr_if.Busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_to_idle busy %b required 0", rr_if.Busy);
        end
        rr_if.Bus_Grant = 1'b1;
        starts = 0; acks = 0; busy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rr_if.ChStart) starts++;
            if (rr_if.ReqAck != 4'b0000) acks++;
        end
        rr_if.DmacReq = 4'b1000;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rr_if.Busy) busy++;
            if (rr_if.ReqAck != 4'b0000) acks++;
        end
        checks++;
        if (starts !== 0 || acks !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL withdraw_disabled starts %0d acks %0d busy %0d required 0 0 0", starts, acks, busy);
        end
        rr_if.DmacReq = 4'b1001;
        exp_q.push_back(0);
        wait_rr_ack(40, ack, m);
        e = exp_q.pop_front();
        rr_if.DmacReq = 4'b0000;
        checks++;
        if (ack !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL disabled_mix_ack got %b required %b", ack, 4'b0001 << e);
        end
        @(negedge clk);
    endtask

    task automatic test_int_clear_collision();
        int m;
        int e;
        logic [3:0] ack;
        checks++;
        if (rr_if.IntStatus !== 4'b0001) begin
            errors++;
            $display("FAIL collision_pre status %b required 0001", rr_if.IntStatus);
        end
        done_dly = 4;
        rr_if.ChEnable = 4'b0010; rr_if.DmacReq = 4'b0010; rr_if.Bus_Grant = 1'b1;
        exp_q.push_back(1);
        wait_rr_ack(40, ack, m);
        rr_if.IntClear = 4'b0011;
        rr_if.DmacReq = 4'b0000;
        e = exp_q.pop_front();
        checks++;
        if (ack !== (4'b0001 << e)) begin
            errors++;
            $display("FAIL collision_ack got %b required %b", ack, 4'b0001 << e);
        end
        @(negedge clk);
        rr_if.IntClear = 4'b0000;
        checks++;
        if (rr_if.IntStatus !== 4'b0010) begin
            errors++;
            $display("FAIL collision_status got %b required 0010", rr_if.IntStatus);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        int m;
        int e;
        int acks;
        logic [3:0] ack;
        done_dly = 20;
        rr_if.ChEnable = 4'b1111; rr_if.DmacReq = 4'b0100; rr_if.Bus_Grant = 1'b1;
        wait_rr_start(20, n);
        @(negedge clk);
        rr_if.Bus_Grant = 1'b0;
        #1;
        checks++;
        if (rr_if.ChHold !== 1'b1 || rr_if.Busy !== 1'b1 || rr_if.Bus_Req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre hold %b busy %b bus_req %b required 1 1 1",
                     rr_if.ChHold, rr_if.Busy, rr_if.Bus_Req);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rr_if.Bus_Req, rr_if.Busy, rr_if.ChHold} !== 3'b000 || rr_if.ReqAck !== 4'b0000
            || rr_if.IntStatus !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async bus_req %b busy %b hold %b ack %b status %b required all 0",
                     rr_if.Bus_Req, rr_if.Busy, rr_if.ChHold, rr_if.ReqAck, rr_if.IntStatus);
        end
        rr_if.DmacReq = 4'b1111;
        rr_if.Bus_Grant = 1'b1;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (rr_if.ReqAck != 4'b0000) acks++;
        end
        rst = 1'b1;
        exp_q.push_back(0);
        wait_rr_ack(60, ack, m);
        e = exp_q.pop_front();
        rr_if.DmacReq = 4'b0000;
        checks++;
        if (ack !== (4'b0001 << e) || acks !== 0) begin
            errors++;
            $display("FAIL midrst_first_winner got %b acks_in_reset %0d required %b 0", ack, acks, 4'b0001 << e);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_fixed_priority();
        test_grant_delay();
        test_withdraw_disabled();
        test_int_clear_collision();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
